// File: rtl/fb_pixel_writer_if.sv
// rtl/fb_pixel_writer_if.sv - pixel stream and frame-buffer RAM write port bundle
// Purpose: groups the pixel stream handshake and the RAM write port of fb_pixel_writer.
// Signals:
//   s_valid, s_ready, s_data, s_sof   raster-ordered pixel stream
//   mem_busy                          RAM arbiter stall for this cycle
//   wr_en, wr_addr, wr_data           RAM write port
// Modports: slave = the pixel writer, master = its environment (source and RAM).
interface fb_pixel_writer_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_sof;
    logic              mem_busy;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output s_valid, s_data, s_sof, mem_busy,
        input  s_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  s_valid, s_data, s_sof, mem_busy,
        output s_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/fb_pixel_writer.sv
// rtl/fb_pixel_writer.sv - frame buffer write side, raster stream to linear RAM addresses
// Purpose: stores a raster-ordered grayscale pixel stream into the frame buffer at
//   y*H_ACTIVE+x, generating the address incrementally, and flags frame completion.
// Ports:
//   clk_25      pixel clock
//   n_rst       asynchronous active-low reset
//   px          fb_pixel_writer_if.slave (stream in, RAM write port out)
//   frame_done  1-cycle pulse with the write of the last pixel of a frame
//   sof_error   1-cycle pulse with the write of a start-of-frame beat that arrived mid-frame
//   busy        high while a frame is in progress (registered, one cycle behind the state)
module fb_pixel_writer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 8
) (
    input  logic                clk_25,
    input  logic                n_rst,
    fb_pixel_writer_if.slave    px,
    output logic                frame_done,
    output logic                sof_error,
    output logic                busy
);
    typedef enum logic {IDLE, WRITE} state_t;

    localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

    state_t            state, state_n;
    logic [9:0]        x, x_n;
    logic [9:0]        y, y_n;
    logic [ADDR_W-1:0] addr_cnt, addr_n;
    logic              wr_en_n;
    logic [ADDR_W-1:0] wr_addr_n;
    logic [DATA_W-1:0] wr_data_n;
    logic              frame_done_n;
    logic              sof_error_n;
    logic              accept;

    // The stall comes straight from the arbiter, so readiness never depends on state.
    assign px.s_ready = !px.mem_busy;
    assign accept     = px.s_valid && !px.mem_busy;

    always_ff @(posedge clk_25 or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            addr_cnt   <= '0;
            px.wr_en   <= 1'b0;
            px.wr_addr <= '0;
            px.wr_data <= '0;
            frame_done <= 1'b0;
            sof_error  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            x          <= x_n;
            y          <= y_n;
            addr_cnt   <= addr_n;
            px.wr_en   <= wr_en_n;
            px.wr_addr <= wr_addr_n;
            px.wr_data <= wr_data_n;
            frame_done <= frame_done_n;
            sof_error  <= sof_error_n;
            busy       <= (state == WRITE);
        end
    end

    always_comb begin
        state_n      = state;
        x_n          = x;
        y_n          = y;
        addr_n       = addr_cnt;
        wr_en_n      = 1'b0;
        wr_addr_n    = px.wr_addr;
        wr_data_n    = px.wr_data;
        frame_done_n = 1'b0;
        sof_error_n  = 1'b0;

        if (accept) begin
            if (px.s_sof) begin
                // Start of frame wins over everything, including the final-pixel position.
                sof_error_n = (state == WRITE);
                wr_en_n     = 1'b1;
                wr_addr_n   = '0;
                wr_data_n   = px.s_data;
                x_n         = 10'd1;
                y_n         = '0;
                addr_n      = ADDR_W'(1);
                state_n     = WRITE;
            end else if (state == WRITE) begin
                wr_en_n   = 1'b1;
                wr_addr_n = addr_cnt;
                wr_data_n = px.s_data;
                if (x == X_LAST && y == Y_LAST) begin
                    frame_done_n = 1'b1;
                    x_n          = '0;
                    y_n          = '0;
                    addr_n       = '0;
                    state_n      = IDLE;
                end else begin
                    if (x == X_LAST) begin
                        x_n = '0;
                        y_n = y + 10'd1;
                    end else begin
                        x_n = x + 10'd1;
                    end
                    addr_n = addr_cnt + ADDR_W'(1);
                end
            end
            // Beats without a start-of-frame while idle are dropped on purpose.
        end
    end
endmodule

// File: tb/tb_fb_pixel_writer.sv
// tb/tb_fb_pixel_writer.sv - self-checking bench for fb_pixel_writer
module tb_fb_pixel_writer;
    localparam int H      = 640;
    localparam int V      = 8;
    localparam int N      = H * V;
    localparam int ADDR_W = 19;
    localparam int DATA_W = 8;

    logic clk_25;
    logic n_rst;
    logic frame_done;
    logic sof_error;
    logic busy;

    fb_pixel_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) px ();

    fb_pixel_writer #(
        .H_ACTIVE(H),
        .V_ACTIVE(V),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk_25    (clk_25),
        .n_rst     (n_rst),
        .px        (px.slave),
        .frame_done(frame_done),
        .sof_error (sof_error),
        .busy      (busy)
    );

    initial clk_25 = 1'b0;
    always #20 clk_25 = ~clk_25;

    int n_checks = 0;
    int n_fail   = 0;
    int fd_cnt   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a frame is a linear sequence of pixel indices 0..N-1; the index is the address.
    bit                in_frame;
    int                idx;
    bit                m_wr_en;
    int                m_addr;
    logic [DATA_W-1:0] m_data;
    bit                m_fd;
    bit                m_se;
    bit                m_busy;

    always @(posedge clk_25 or negedge n_rst) begin
        if (!n_rst) begin
            in_frame = 0; idx = 0;
            m_wr_en = 0; m_addr = 0; m_data = '0; m_fd = 0; m_se = 0; m_busy = 0;
        end else begin
            m_busy  = in_frame;
            m_wr_en = 0; m_fd = 0; m_se = 0;
            if (px.s_valid && !px.mem_busy) begin
                if (px.s_sof) begin
                    m_se = in_frame;
                    in_frame = 1;
                    m_wr_en = 1; m_addr = 0; m_data = px.s_data;
                    idx = 1;
                end else if (in_frame) begin
                    m_wr_en = 1; m_addr = idx; m_data = px.s_data;
                    if (idx == N - 1) begin
                        m_fd = 1; in_frame = 0; idx = 0;
                    end else begin
                        idx = idx + 1;
                    end
                end
            end
        end
    end

    always @(negedge clk_25) begin
        chk("s_ready", 32'(px.s_ready), 32'(!px.mem_busy));
        chk("wr_en", 32'(px.wr_en), 32'(m_wr_en));
        chk("wr_addr", 32'(px.wr_addr), m_addr);
        chk("wr_data", 32'(px.wr_data), 32'(m_data));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
        chk("sof_error", 32'(sof_error), 32'(m_se));
        chk("busy", 32'(busy), 32'(m_busy));
        if (px.wr_en && frame_done) fd_cnt++;
    end

    logic [DATA_W-1:0] dv;
    logic [DATA_W-1:0] saved;

    task automatic step(input logic v, input logic sof, input logic mb);
        px.s_valid  = v;
        px.s_sof    = sof;
        px.mem_busy = mb;
        px.s_data   = dv;
        @(posedge clk_25);
        #1;
        if (v && !mb) dv = dv + 8'd37;
    endtask

    task automatic feed(input int n);
        repeat (n) step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_en"}, 32'(px.wr_en), 32'd0);
        chk({tag, "_wr_addr"}, 32'(px.wr_addr), 32'd0);
        chk({tag, "_wr_data"}, 32'(px.wr_data), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_sof_error"}, 32'(sof_error), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        n_rst       = 1'b0;
        px.s_valid  = 1'b0;
        px.s_sof    = 1'b0;
        px.mem_busy = 1'b0;
        px.s_data   = '0;
        dv          = 8'h05;
        repeat (3) begin
            @(posedge clk_25);
            #1;
        end
        chk_all_zero("reset");
        n_rst = 1'b1;

        // Full frame, contiguous stream
        saved = dv;
        step(1'b1, 1'b1, 1'b0);
        chk("t1_first_en", 32'(px.wr_en), 32'd1);
        chk("t1_first_addr", 32'(px.wr_addr), 32'd0);
        chk("t1_first_data", 32'(px.wr_data), 32'(saved));
        feed(1);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_addr1", 32'(px.wr_addr), 32'd1);
        feed(N - 3);
        step(1'b1, 1'b0, 1'b0);
        chk("t1_last_addr", 32'(px.wr_addr), 32'd5119);
        chk("t1_frame_done", 32'(frame_done), 32'd1);
        chk("t1_busy_last", 32'(busy), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        chk("t1_busy_drop", 32'(busy), 32'd0);
        chk("t1_fd_after", 32'(frame_done), 32'd0);
        chk("t1_fd_count", 32'(fd_cnt), 32'd1);

        // Beats without start-of-frame while idle are discarded
        repeat (5) begin
            step(1'b1, 1'b0, 1'b0);
            chk("t2_no_write", 32'(px.wr_en), 32'd0);
        end
        step(1'b1, 1'b1, 1'b0);
        chk("t2_sof_en", 32'(px.wr_en), 32'd1);
        chk("t2_sof_addr", 32'(px.wr_addr), 32'd0);
        chk("t2_sof_err", 32'(sof_error), 32'd0);

        // Mid-frame start-of-frame at pixel index 1000
        feed(999);
        chk("t4_addr999", 32'(px.wr_addr), 32'd999);
        step(1'b1, 1'b1, 1'b0);
        chk("t4_sof_error", 32'(sof_error), 32'd1);
        chk("t4_restart_addr", 32'(px.wr_addr), 32'd0);
        chk("t4_no_fd", 32'(frame_done), 32'd0);
        step(1'b1, 1'b0, 1'b0);
        chk("t4_next_addr", 32'(px.wr_addr), 32'd1);
        chk("t4_err_clear", 32'(sof_error), 32'd0);

        // Line wrap
        feed(637);
        step(1'b1, 1'b0, 1'b0);
        chk("t5_addr639", 32'(px.wr_addr), 32'd639);
        step(1'b1, 1'b0, 1'b0);
        chk("t5_addr640", 32'(px.wr_addr), 32'd640);

        // Arbiter stall at x=100, y=2
        feed(739);
        chk("t3_addr1379", 32'(px.wr_addr), 32'd1379);
        saved = dv;
        repeat (3) begin
            step(1'b1, 1'b0, 1'b1);
            chk("t3_ready_low", 32'(px.s_ready), 32'd0);
            chk("t3_no_write", 32'(px.wr_en), 32'd0);
            chk("t3_addr_hold", 32'(px.wr_addr), 32'd1379);
        end
        step(1'b1, 1'b0, 1'b0);
        chk("t3_addr1380", 32'(px.wr_addr), 32'd1380);
        chk("t3_data1380", 32'(px.wr_data), 32'(saved));
        step(1'b1, 1'b0, 1'b0);
        chk("t3_addr1381", 32'(px.wr_addr), 32'd1381);

        // Reset mid-frame at address 5000
        feed(3618);
        step(1'b1, 1'b0, 1'b0);
        chk("t6_addr5000", 32'(px.wr_addr), 32'd5000);
        n_rst = 1'b0;
        #1;
        chk_all_zero("t6_async");
        repeat (2) begin
            @(posedge clk_25);
            #1;
            chk_all_zero("t6_held");
        end
        n_rst = 1'b1;
        repeat (3) begin
            step(1'b1, 1'b0, 1'b0);
            chk("t6_no_write", 32'(px.wr_en), 32'd0);
        end
        step(1'b1, 1'b1, 1'b0);
        chk("t6_sof_addr", 32'(px.wr_addr), 32'd0);
        chk("t6_sof_err", 32'(sof_error), 32'd0);

        // Start-of-frame on the final pixel position takes priority
        feed(N - 2);
        chk("t7_addr5118", 32'(px.wr_addr), 32'd5118);
        step(1'b1, 1'b1, 1'b0);
        chk("t7_sof_error", 32'(sof_error), 32'd1);
        chk("t7_no_fd", 32'(frame_done), 32'd0);
        chk("t7_addr0", 32'(px.wr_addr), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("t7_fd_count", 32'(fd_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
